if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'hE600_0000: bubble instruction (MVI R0,0).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port imem_addr, output, 32: byte address to instruction memory, equal to the current PC.
REQ-006 SHALL have port imem_instr, input, 32: instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port stall, input, 1: hazard unit hold request (load-use).
REQ-008 SHALL have port branch_taken, input, 1: redirect request from execute.
REQ-009 SHALL have port branch_target, input, 32: redirect byte address, sampled when branch_taken=1.
REQ-010 SHALL have port if_id_instr, output, 32: registered instruction to decode.
REQ-011 SHALL have port if_id_pc, output, 32: registered address of if_id_instr.
REQ-012 SHALL have port if_id_pc_plus4, output, 32: registered if_id_pc+4.
REQ-013 SHALL have port if_id_valid, output, 1: 1 = if_id_instr is a real fetched instruction, 0 = bubble.
REQ-014 SHALL have port fetch_count, output, 16: instructions delivered to IF/ID since reset.
REQ-015 SHALL have port flush_count, output, 16: redirects taken since reset.

Function
REQ-016 SHALL drive imem_addr combinationally from the PC register, with no added latency.
REQ-017 SHALL, on a normal cycle (branch_taken=0, stall=0), load IF/ID with {imem_instr, PC, PC+4, valid=1}, advance PC by 4, and increment fetch_count; fetch-to-decode latency is one cycle.
REQ-018 SHALL, when stall=1 and branch_taken=0, hold PC, all IF/ID outputs, and fetch_count unchanged.
REQ-019 SHALL give branch_taken priority over stall: load PC with {branch_target[31:2],2'b00}, load IF/ID with {NOP_INSTR, 0, 0, valid=0}, increment flush_count, and leave fetch_count unchanged.
REQ-020 SHALL always force the low two PC bits to zero, including for a misaligned branch_target.
REQ-021 SHALL wrap PC from 32'hFFFF_FFFC to 32'h0000_0000 without a flag; if_id_pc_plus4 wraps the same way.
REQ-022 SHALL implement FSM states RUN and REDIR; reset enters RUN; any branch_taken moves to REDIR; in REDIR a normal fetch returns to RUN, stall holds REDIR, and branch_taken re-enters REDIR with the new target.
REQ-023 SHALL keep if_id_valid=0 for every cycle spent in REDIR, so exactly one bubble follows each redirect even when a stall extends it.
REQ-024 SHALL saturate fetch_count and flush_count at 16'hFFFF.
REQ-025 SHALL apply back-to-back branch_taken on consecutive cycles to the most recent target only.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, set PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, both counters=0, and state=RUN, regardless of stall or branch_taken.
REQ-027 SHALL fetch RESET_PC on the first edge after rst_n returns high; imem_addr equals RESET_PC throughout reset.
REQ-028 SHALL discard a redirect or stall in progress when reset is asserted mid-operation.

Structure
REQ-029 SHALL take NOP_INSTR, the state encodings (RUN, REDIR), and the 32-bit address width from the shared cpu package.
REQ-030 SHALL contain one sub-module, sat_counter16 (enable, synchronous active-low clear, saturating), instantiated twice.
REQ-031 SHALL contain no memory; instruction memory remains a separate instance driven by imem_addr.

Verification
REQ-032 SHALL cover linear fetch: reset then 4 free cycles with the standard test program -> if_id_pc 0,4,8,C, if_id_instr E680100A/E6802014/E0213000/E9234004 on words 0-3, fetch_count=4.
REQ-033 SHALL cover stall: stall=1 for 2 cycles with PC=0x10 -> imem_addr stays 0x10, IF/ID is unchanged, and fetch resumes at 0x10 afterwards.
REQ-034 SHALL cover redirect: branch_taken=1 with target 0x00 at PC=0x20 -> next cycle if_id_valid=0, if_id_instr=E6000000, imem_addr=0x00, flush_count=1, then if_id_pc=0 with valid=1.
REQ-035 SHALL cover simultaneous stall and branch: both high with target 0x1B -> PC=0x18 and a bubble is issued; stall held in REDIR keeps valid=0.
REQ-036 SHALL cover wrap and reset: PC forced to 0xFFFFFFFC via redirect, then one free cycle -> if_id_pc_plus4=0 and imem_addr=0; rst_n low mid-REDIR -> all REQ-026 values on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address width, bubble instruction, fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W = 32;

  // MVI R0,0 -- architecturally harmless, used as the pipeline bubble.
  localparam logic [31:0] CPU_NOP_INSTR = 32'hE600_0000;

  // RUN: fetching normally. REDIR: a redirect has just been taken and IF/ID
  // holds a bubble until the first normal fetch from the new target.
  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } if_state_e;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
// Latency: count reflects an enabled cycle on the following edge.
// Backpressure: none; i_clr_n (synchronous, active-low) overrides i_en.
//
// Ports:
//   i_clk   - clock
//   i_clr_n - synchronous active-low clear
//   i_en    - count one event this cycle
//   o_count - current count
module sat_counter16 (
  input  logic        i_clk,
  input  logic        i_clr_n,
  input  logic        i_en,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_count <= 16'd0;
    end else if (i_en && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/stall handling.
// Latency: 1 cycle from imem_addr to IF/ID; imem_addr is the PC with no added delay.
// Backpressure: stall holds PC and IF/ID; branch_taken wins over stall and inserts one bubble.
//
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   imem_addr / imem_instr      - combinational instruction memory interface
//   stall                       - hold request from hazard unit
//   branch_taken/branch_target  - redirect request from execute
//   if_id_instr/pc/pc_plus4/valid - IF/ID register to decode
//   fetch_count / flush_count   - saturating delivered-instruction and redirect counters
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
);

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_pc_plus4;
  logic              r_if_valid;
  if_state_e         r_state;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_target;
  logic              w_fetch_en;

  // Word alignment is enforced here so a misaligned target can never reach the PC.
  assign w_target   = branch_target & ~32'h0000_0003;
  // Natural 32-bit wrap from FFFF_FFFC to 0 is intended.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_fetch_en = !branch_taken && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC & ~32'h0000_0003;
      r_if_instr    <= NOP_INSTR;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_valid    <= 1'b0;
      r_state       <= RUN;
    end else if (branch_taken) begin
      // A later redirect simply overwrites an earlier one: only the newest target survives.
      r_pc          <= w_target;
      r_if_instr    <= NOP_INSTR;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_valid    <= 1'b0;
      r_state       <= REDIR;
    end else if (stall) begin
      // Hold everything. While in REDIR the bubble must stay a bubble for as
      // long as the stall lasts.
      if (r_state == REDIR) begin
        r_if_valid <= 1'b0;
      end
    end else begin
      r_pc          <= w_pc_plus4;
      r_if_instr    <= imem_instr;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= w_pc_plus4;
      r_if_valid    <= 1'b1;
      r_state       <= RUN;
    end
  end

  sat_counter16 u_fetch_cnt (
    .i_clk   (clk),
    .i_clr_n (rst_n),
    .i_en    (w_fetch_en),
    .o_count (fetch_count)
  );

  sat_counter16 u_flush_cnt (
    .i_clk   (clk),
    .i_clr_n (rst_n),
    .i_en    (branch_taken),
    .o_count (flush_count)
  );

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_if_instr;
  assign if_id_pc       = r_if_pc;
  assign if_id_pc_plus4 = r_if_pc_plus4;
  assign if_id_valid    = r_if_valid;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: instruction-memory stand-in, transaction-level reference model,
// per-cycle comparison of every output plus hand-computed literal checkpoints.
// Terminates by itself after a fixed directed sequence.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'hE600_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [15:0] fetch_count;
  logic [15:0] flush_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard test program in words 0-3; elsewhere a word tagged with its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'hE680_100A;
      32'h4:   mem_word = 32'hE680_2014;
      32'h8:   mem_word = 32'hE021_3000;
      32'hC:   mem_word = 32'hE923_4004;
      default: mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction per clock edge, described by outcome.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid;
  int          m_fetch, m_flush;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
      m_fetch = 0; m_flush = 0;
    end else if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_instr = NOP; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
      if (m_flush < 65535) m_flush++;
    end else if (!stall) begin
      m_instr = mem_word(m_pc);
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
      if (m_fetch < 65535) m_fetch++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_imem_addr", imem_addr, m_pc);
      check("cyc_instr", if_id_instr, m_instr);
      check("cyc_pc", if_id_pc, m_ipc);
      check("cyc_pc_plus4", if_id_pc_plus4, m_ipc4);
      check("cyc_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check("cyc_fetch_count", {16'd0, fetch_count}, m_fetch);
      check("cyc_flush_count", {16'd0, flush_count}, m_flush);
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the consuming edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst_n = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
    check({tag, "_instr"}, if_id_instr, 32'hE600_0000);
    check({tag, "_pc"}, if_id_pc, 32'h0);
    check({tag, "_pc4"}, if_id_pc_plus4, 32'h0);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, "_fetch"}, {16'd0, fetch_count}, 32'd0);
    check({tag, "_flush"}, {16'd0, flush_count}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

    // Reset wins over stall and branch.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    cmp_en = 1'b1;
    check_reset_state("reset");

    // Linear fetch of the standard program.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("lin0_pc", if_id_pc, 32'h0);
    check("lin0_instr", if_id_instr, 32'hE680_100A);
    check("lin0_valid", {31'd0, if_id_valid}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("lin1_pc", if_id_pc, 32'h4);
    check("lin1_instr", if_id_instr, 32'hE680_2014);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("lin2_pc", if_id_pc, 32'h8);
    check("lin2_instr", if_id_instr, 32'hE021_3000);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("lin3_pc", if_id_pc, 32'hC);
    check("lin3_instr", if_id_instr, 32'hE923_4004);
    check("lin3_pc4", if_id_pc_plus4, 32'h10);
    check("lin_fetch_count", {16'd0, fetch_count}, 32'd4);

    // Stall two cycles at PC=0x10.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_imem_addr", imem_addr, 32'h10);
    check("stall_pc_held", if_id_pc, 32'hC);
    check("stall_instr_held", if_id_instr, 32'hE923_4004);
    check("stall_fetch_held", {16'd0, fetch_count}, 32'd4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("resume_pc", if_id_pc, 32'h10);
    check("resume_instr", if_id_instr, 32'hC0DE_0010);

    // Redirect to 0 from PC=0x20.
    free(3);
    check("pre_redir_addr", imem_addr, 32'h20);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    check("redir_valid", {31'd0, if_id_valid}, 32'd0);
    check("redir_instr", if_id_instr, 32'hE600_0000);
    check("redir_imem_addr", imem_addr, 32'h0);
    check("redir_flush", {16'd0, flush_count}, 32'd1);
    check("redir_fetch", {16'd0, fetch_count}, 32'd8);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("after_redir_pc", if_id_pc, 32'h0);
    check("after_redir_valid", {31'd0, if_id_valid}, 32'd1);

    // Stall and branch together, misaligned target, then stall inside REDIR.
    step(1'b1, 1'b1, 1'b1, 32'h0000_001B);
    check("sb_imem_addr", imem_addr, 32'h18);
    check("sb_valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("sb_stall_valid", {31'd0, if_id_valid}, 32'd0);
    check("sb_stall_addr", imem_addr, 32'h18);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("sb_resume_pc", if_id_pc, 32'h18);
    check("sb_resume_valid", {31'd0, if_id_valid}, 32'd1);

    // Back-to-back redirects: only the newest target counts.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0080);
    check("b2b_addr", imem_addr, 32'h80);
    check("b2b_flush", {16'd0, flush_count}, 32'd4);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("b2b_pc", if_id_pc, 32'h80);

    // Wrap at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_id_pc_plus4, 32'h0);
    check("wrap_imem_addr", imem_addr, 32'h0);

    // Reset in the middle of REDIR with a stall pending.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_reset_state("midreset");
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("postreset_pc", if_id_pc, 32'h0);
    check("postreset_instr", if_id_instr, 32'hE680_100A);
    check("postreset_fetch", {16'd0, fetch_count}, 32'd1);
    free(2);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
